serdes_tx_framer: RTL and testbench

Transmit-side framer for the SERDES link. It accepts 8-bit parallel words over a valid/ready handshake and wraps each one in a 10-bit frame: a start bit, 8 data bits sent LSB-first, and a stop bit. It then shifts the frame out serially, holding each bit for a programmable number of clocks. It sits directly upstream of the receive-side bit counter and exports a matching bits-remaining count and an end-of-frame pulse.

---
 rtl/serdes_tx_framer_if.sv | 19 +
 rtl/serdes_tx_framer.sv | 118 +++++++++++
 tb/tb_serdes_tx_framer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/serdes_tx_framer_if.sv
// Parallel-word valid/ready handshake into the SERDES transmit framer.
// The master (upstream) drives data/valid; the framer answers with ready.
interface serdes_tx_framer_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/serdes_tx_framer.sv
// Transmit framer: buffers one parallel word and shifts it out as a 10-bit
// start/data(LSB first)/stop frame, each bit held for CLKS_PER_BIT clocks.
module serdes_tx_framer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic                clk,
    input  logic                ResetN,
    serdes_tx_framer_if.slave   tx,
    output logic                ser_out,
    output logic                busy,
    output logic [3:0]          bits_left,
    output logic                frame_done
);

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    localparam logic [15:0] BaudLast = 16'(CLKS_PER_BIT - 1);

    state_e      state_q, state_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_full_q, hold_full_d;
    logic [9:0]  shift_q, shift_d;
    logic [15:0] baud_q, baud_d;
    logic [3:0]  bits_left_q, bits_left_d;
    logic        ser_q, ser_d;
    logic        busy_q, busy_d;

    logic accept;
    logic bit_end;
    logic start_frame;

    assign tx.tx_ready = ~hold_full_q;
    assign accept      = tx.tx_valid & ~hold_full_q;
    assign bit_end     = (baud_q == BaudLast);

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        baud_d      = baud_q;
        bits_left_d = bits_left_q;
        ser_d       = ser_q;
        busy_d      = busy_q;
        start_frame = 1'b0;

        // Accept and load are exclusive: loading needs hold_full, accepting needs it clear.
        if (accept) begin
            hold_d      = tx.tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                start_frame = hold_full_q;
            end
            StShift: begin
                if (!bit_end) begin
                    baud_d = baud_q + 16'd1;
                end else if (bits_left_q != 4'd0) begin
                    shift_d     = {1'b1, shift_q[9:1]};
                    ser_d       = shift_q[1];
                    bits_left_d = bits_left_q - 4'd1;
                    baud_d      = 16'd0;
                end else if (hold_full_q) begin
                    start_frame = 1'b1;
                end else begin
                    state_d     = StIdle;
                    ser_d       = 1'b1;
                    busy_d      = 1'b0;
                    bits_left_d = 4'd0;
                    baud_d      = 16'd0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (start_frame) begin
            shift_d     = {1'b1, hold_q, 1'b0};
            ser_d       = 1'b0;
            bits_left_d = 4'd9;
            baud_d      = 16'd0;
            state_d     = StShift;
            busy_d      = 1'b1;
            hold_full_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q     <= StIdle;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            shift_q     <= '1;
            baud_q      <= 16'd0;
            bits_left_q <= 4'd0;
            ser_q       <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bits_left_q <= bits_left_d;
            ser_q       <= ser_d;
            busy_q      <= busy_d;
        end
    end

    assign ser_out    = ser_q;
    assign busy       = busy_q;
    assign bits_left  = bits_left_q;
    assign frame_done = (state_q == StShift) && (bits_left_q == 4'd0) && bit_end;

endmodule

// File: tb/tb_serdes_tx_framer.sv
// Directed bench for serdes_tx_framer: one instance at 4 clocks/bit, one at 1 clock/bit.
module tb_serdes_tx_framer;

    logic clk;
    logic rst_n;

    serdes_tx_framer_if if4 ();
    serdes_tx_framer_if if1 ();

    logic       ser4, busy4, fd4;
    logic [3:0] bl4;
    logic       ser1, busy1, fd1;
    logic [3:0] bl1;

    serdes_tx_framer #(.CLKS_PER_BIT(4)) u_dut4 (
        .clk        (clk),
        .ResetN     (rst_n),
        .tx         (if4.slave),
        .ser_out    (ser4),
        .busy       (busy4),
        .bits_left  (bl4),
        .frame_done (fd4)
    );

    serdes_tx_framer #(.CLKS_PER_BIT(1)) u_dut1 (
        .clk        (clk),
        .ResetN     (rst_n),
        .tx         (if1.slave),
        .ser_out    (ser1),
        .busy       (busy1),
        .bits_left  (bl1),
        .frame_done (fd1)
    );

    // Stimulus goes to the selected instance; observed signals are muxed from it.
    logic       use1;
    logic       drv_valid;
    logic [7:0] drv_data;

    assign if4.tx_valid = drv_valid & ~use1;
    assign if4.tx_data  = drv_data;
    assign if1.tx_valid = drv_valid & use1;
    assign if1.tx_data  = drv_data;

    logic       m_ser, m_busy, m_fd, m_ready;
    logic [3:0] m_bl;
    assign m_ser   = use1 ? ser1  : ser4;
    assign m_busy  = use1 ? busy1 : busy4;
    assign m_fd    = use1 ? fd1   : fd4;
    assign m_bl    = use1 ? bl1   : bl4;
    assign m_ready = use1 ? if1.tx_ready : if4.tx_ready;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check($sformatf("%s ser_out", tag), 32'(m_ser), 32'd1);
        check($sformatf("%s busy", tag), 32'(m_busy), 32'd0);
        check($sformatf("%s bits_left", tag), 32'(m_bl), 32'd0);
        check($sformatf("%s frame_done", tag), 32'(m_fd), 32'd0);
        check($sformatf("%s tx_ready", tag), 32'(m_ready), 32'd1);
    endtask

    // Called just after a posedge in a cycle where tx_ready=1; returns in cycle 0.
    task automatic send_word(input logic [7:0] d);
        drv_data  = d;
        drv_valid = 1'b1;
        @(negedge clk);
        check("ready_before_xfer", 32'(m_ready), 32'd1);
        @(posedge clk);
        #1;
        drv_valid = 1'b0;
        @(negedge clk);
        check("ready_cycle0", 32'(m_ready), 32'd0);
    endtask

    // Called during cycle 0 (before the load edge); checks cycles 1..10*clks.
    task automatic check_frame(input logic [9:0] bits, input int clks, input string tag);
        int slot;
        for (int c = 1; c <= 10 * clks; c++) begin
            @(posedge clk);
            @(negedge clk);
            slot = (c - 1) / clks;
            check($sformatf("%s c%0d ser_out", tag, c), 32'(m_ser), 32'(bits[slot]));
            check($sformatf("%s c%0d bits_left", tag, c), 32'(m_bl), 32'(9 - slot));
            check($sformatf("%s c%0d busy", tag, c), 32'(m_busy), 32'd1);
            check($sformatf("%s c%0d frame_done", tag, c), 32'(m_fd),
                  (c == 10 * clks) ? 32'd1 : 32'd0);
            if (c == 1) check($sformatf("%s c1 tx_ready", tag), 32'(m_ready), 32'd1);
        end
    endtask

    typedef struct {
        bit         sel1;
        logic [7:0] data;
        logic [9:0] bits;   // bits[k] is frame slot k on the line
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{sel1: 1'b0, data: 8'hA5, bits: 10'b1101001010};
        vecs[1] = '{sel1: 1'b1, data: 8'h81, bits: 10'b1100000010};
        vecs[2] = '{sel1: 1'b0, data: 8'h3C, bits: 10'b1001111000};
        vecs[3] = '{sel1: 1'b1, data: 8'h5A, bits: 10'b1010110100};
        vecs[4] = '{sel1: 1'b0, data: 8'h00, bits: 10'b1000000000};

        use1      = 1'b0;
        drv_valid = 1'b0;
        drv_data  = 8'h00;
        rst_n     = 1'b0;

        // Reset values on both instances
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("rst4");
        use1 = 1'b1;
        check_idle("rst1");
        use1 = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("post_rst");
        end

        // Table-driven single frames
        for (int i = 0; i < 5; i++) begin
            use1 = vecs[i].sel1;
            @(posedge clk);
            #1;
            send_word(vecs[i].data);
            check_frame(vecs[i].bits, vecs[i].sel1 ? 1 : 4, $sformatf("vec%0d", i));
            @(posedge clk);
            @(negedge clk);
            check_idle($sformatf("vec%0d after", i));
        end

        // Back-to-back: 0x00 then 0xFF offered in cycle 1
        use1 = 1'b0;
        @(posedge clk);
        #1;
        send_word(8'h00);
        fork
            begin
                check_frame(10'b1000000000, 4, "b2b0");
                check_frame(10'b1111111110, 4, "b2b1");
            end
            begin
                @(posedge clk);
                #1;
                drv_data  = 8'hFF;
                drv_valid = 1'b1;
                @(posedge clk);
                #1;
                drv_valid = 1'b0;
                @(negedge clk);
                check("b2b ready_cycle2", 32'(m_ready), 32'd0);
            end
        join
        @(posedge clk);
        @(negedge clk);
        check_idle("b2b after");

        // Not-ready hold: 0x3C waits behind 0x5A while hold_full=1
        @(posedge clk);
        #1;
        send_word(8'h81);
        fork
            begin
                check_frame(10'b1100000010, 4, "hold0");
                check_frame(10'b1010110100, 4, "hold1");
                check_frame(10'b1001111000, 4, "hold2");
            end
            begin
                @(posedge clk);
                #1;
                drv_data  = 8'h5A;
                drv_valid = 1'b1;
                @(posedge clk);
                #1;
                drv_data = 8'h3C;
                @(negedge clk);
                check("hold ready_cycle2", 32'(m_ready), 32'd0);
                repeat (39) @(posedge clk);
                @(negedge clk);
                check("hold ready_cycle41", 32'(m_ready), 32'd1);
                @(posedge clk);
                #1;
                drv_valid = 1'b0;
                @(negedge clk);
                check("hold ready_cycle42", 32'(m_ready), 32'd0);
            end
        join
        @(posedge clk);
        @(negedge clk);
        check_idle("hold after");

        // Reset mid-frame at cycle 15 of a 0x5A frame
        @(posedge clk);
        #1;
        send_word(8'h5A);
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("midrst immediate");
        repeat (3) begin
            @(negedge clk);
            check("midrst frame_done", 32'(m_fd), 32'd0);
            check("midrst busy", 32'(m_busy), 32'd0);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("midrst released");
        @(posedge clk);
        #1;
        send_word(8'h81);
        check_frame(10'b1100000010, 4, "midrst next");
        @(posedge clk);
        @(negedge clk);
        check_idle("midrst next after");

        // Minimum rate back-to-back on the 1-clock instance
        use1 = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'hA5);
        fork
            begin
                check_frame(10'b1101001010, 1, "min0");
                check_frame(10'b1100000010, 1, "min1");
            end
            begin
                @(posedge clk);
                #1;
                drv_data  = 8'h81;
                drv_valid = 1'b1;
                @(posedge clk);
                #1;
                drv_valid = 1'b0;
            end
        join
        @(posedge clk);
        @(negedge clk);
        check_idle("min after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
